sha1_controller: RTL and testbench
==================================

SHA1_CONTROLLER -- requirements
Module: sha1_controller

Interface
REQ-001 Parameters: none; all loop bounds and widths are fixed.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  request to hash the 16-word message already in RAM words 0..15.
REQ-005 j_lt_chunks, l_lt_choose, l_lt_parity_one, l_lt_major, l_lt_parity_two  in  1 each  datapath loop flags.
REQ-006 busy  out  1  high in every state except IDLE.
REQ-007 en_j, s_j, en_l, s_l, en_read_l, en_reassign, s_reassign, en_temp, s_temp, en_done, s_done, en_fk, en_update_hash, s_update_hash  out  1 each  datapath controls.
REQ-008 en_fill_chunks, en_read_1..en_read_4, en_fill_1..en_fill_4  out  1 each  datapath controls.
REQ-009 s_fk  out  3  function select: 1 choose, 2 parity-1, 3 parity-2, 4 major.

Function
REQ-010 Each output SHALL be high only in the states listed below and low otherwise; all outputs SHALL be registered-state decodes except s_fk, which decodes state plus flags.
REQ-011 States SHALL be: IDLE, INIT, RD1, W1, F1, W2, F2, W3, F3, W4, F4, WR, INC, CHK, RNDINIT, RL, RW, RT, RA, RC, HASH, DONE.
REQ-012 IDLE: go to INIT when start=1; otherwise stay.
REQ-013 start SHALL be ignored in every state other than IDLE.
REQ-014 INIT: assert en_j+s_j, en_l+s_l, en_reassign+s_reassign, en_update_hash+s_update_hash, en_done+s_done (clears done); go to RD1.
REQ-015 Expansion, one pass per word j: the pass SHALL run 12 cycles in the order RD1, W1, F1, W2, F2, W3, F3, W4, F4, WR, INC, CHK.
REQ-016 Expansion enables per state: RD1 en_read_1; F1 en_fill_1+en_read_2; F2 en_fill_2+en_read_3; F3 en_fill_3+en_read_4; F4 en_fill_4; WR en_fill_chunks; INC en_j.
REQ-017 The W states SHALL assert nothing; they cover the one-cycle synchronous RAM read latency.
REQ-018 CHK: go to RD1 if j_lt_chunks=1, else go to RNDINIT; there SHALL be 64 passes (j=16..79).
REQ-019 RNDINIT: assert en_l+s_l and en_read_1 (deasserts RAM write enable); go to RL.
REQ-020 RL: assert en_read_l and en_fk; go to RW.
REQ-021 s_fk in RL SHALL be: 1 if l_lt_choose; else 2 if l_lt_parity_one; else 4 if l_lt_major; else 3.
REQ-022 s_fk SHALL be 0 outside RL.
REQ-023 RW: no enables; go to RT. RT: en_temp (s_temp=0); go to RA.
REQ-024 RA: en_reassign (s_reassign=0) and en_l; go to RC.
REQ-025 RC: go to RL if l_lt_parity_two=1, else go to HASH; there SHALL be 80 rounds.
REQ-026 HASH: en_update_hash (s_update_hash=0); go to DONE.
REQ-027 DONE: en_done (s_done=0); go to IDLE.
REQ-028 Latency: done SHALL rise at the 1172nd rising edge after the edge that samples start (INIT 1 + 768 + RNDINIT 1 + 400 + HASH 1 + DONE 1 cycles).
REQ-029 No enable and its paired select SHALL ever conflict: every s_* SHALL be 0 whenever its en_* is 0.

Reset
REQ-030 rst=1 SHALL force state IDLE immediately, busy=0, every output 0 (s_fk=0), independent of clk.
REQ-031 Reset mid-operation SHALL abandon the hash; datapath registers are not reset by this block, and the next start SHALL reinitialise them via INIT.
REQ-032 After rst falls, the first start accepted SHALL behave identically to one after power-up.

Verification
REQ-033 rst pulse, then start=1 for 1 cycle with RAM 0..15 = padded "abc" -> done=1 after exactly 1172 edges; result = SHA-1 of "abc" computed with the datapath's initial hash constants.
REQ-034 Monitor expansion -> exactly 64 en_fill_chunks pulses; each pass's en_read_1..4 spaced 2 cycles apart.
REQ-035 Monitor rounds -> s_fk = 1 for rounds 0-19, 2 for 20-39, 4 for 40-59, 3 for 60-79; 80 en_temp pulses.
REQ-036 start held high throughout the run -> single run, busy stays 1; IDLE exits to INIT on the next edge after DONE.
REQ-037 rst asserted in state RT of round 37 -> outputs 0 without a clock edge; a new start gives the correct digest and done=1.
REQ-038 Two back-to-back messages -> second INIT clears done to 0; second digest correct and independent of the first.

Source files
------------

// File: rtl/sha1_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sha1_controller
//  Description : Control FSM for a single-block SHA-1 datapath. Sequences
//                message-schedule expansion (W16..W79), the 80 compression
//                rounds, the final hash update and the done flag.
//  Revision    : 1.0  initial release
// ============================================================================
module sha1_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       j_lt_chunks,
    input  logic       l_lt_choose,
    input  logic       l_lt_parity_one,
    input  logic       l_lt_major,
    input  logic       l_lt_parity_two,
    output logic       busy,
    output logic       en_j,
    output logic       s_j,
    output logic       en_l,
    output logic       s_l,
    output logic       en_read_l,
    output logic       en_reassign,
    output logic       s_reassign,
    output logic       en_temp,
    output logic       s_temp,
    output logic       en_done,
    output logic       s_done,
    output logic       en_fk,
    output logic       en_update_hash,
    output logic       s_update_hash,
    output logic       en_fill_chunks,
    output logic       en_read_1,
    output logic       en_read_2,
    output logic       en_read_3,
    output logic       en_read_4,
    output logic       en_fill_1,
    output logic       en_fill_2,
    output logic       en_fill_3,
    output logic       en_fill_4,
    output logic [2:0] s_fk
);

    typedef enum logic [4:0] {
        S_IDLE    = 5'd0,
        S_INIT    = 5'd1,
        S_RD1     = 5'd2,
        S_W1      = 5'd3,
        S_F1      = 5'd4,
        S_W2      = 5'd5,
        S_F2      = 5'd6,
        S_W3      = 5'd7,
        S_F3      = 5'd8,
        S_W4      = 5'd9,
        S_F4      = 5'd10,
        S_WR      = 5'd11,
        S_INC     = 5'd12,
        S_CHK     = 5'd13,
        S_RNDINIT = 5'd14,
        S_RL      = 5'd15,
        S_RW      = 5'd16,
        S_RT      = 5'd17,
        S_RA      = 5'd18,
        S_RC      = 5'd19,
        S_HASH    = 5'd20,
        S_DONE    = 5'd21
    } state_t;

    localparam logic [2:0] FK_NONE   = 3'd0;
    localparam logic [2:0] FK_CHOOSE = 3'd1;
    localparam logic [2:0] FK_PAR1   = 3'd2;
    localparam logic [2:0] FK_PAR2   = 3'd3;
    localparam logic [2:0] FK_MAJOR  = 3'd4;

    state_t state_q;
    state_t state_d;

    // State register; reset drops straight to IDLE without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at while idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = start ? S_INIT : S_IDLE;
            S_INIT:    state_d = S_RD1;
            S_RD1:     state_d = S_W1;
            S_W1:      state_d = S_F1;
            S_F1:      state_d = S_W2;
            S_W2:      state_d = S_F2;
            S_F2:      state_d = S_W3;
            S_W3:      state_d = S_F3;
            S_F3:      state_d = S_W4;
            S_W4:      state_d = S_F4;
            S_F4:      state_d = S_WR;
            S_WR:      state_d = S_INC;
            S_INC:     state_d = S_CHK;
            S_CHK:     state_d = j_lt_chunks ? S_RD1 : S_RNDINIT;
            S_RNDINIT: state_d = S_RL;
            S_RL:      state_d = S_RW;
            S_RW:      state_d = S_RT;
            S_RT:      state_d = S_RA;
            S_RA:      state_d = S_RC;
            S_RC:      state_d = l_lt_parity_two ? S_RL : S_HASH;
            S_HASH:    state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output decode of the registered state; only s_fk also looks at flags.
    always_comb begin
        busy           = (state_q != S_IDLE);
        en_j           = 1'b0;
        s_j            = 1'b0;
        en_l           = 1'b0;
        s_l            = 1'b0;
        en_read_l      = 1'b0;
        en_reassign    = 1'b0;
        s_reassign     = 1'b0;
        en_temp        = 1'b0;
        s_temp         = 1'b0;
        en_done        = 1'b0;
        s_done         = 1'b0;
        en_fk          = 1'b0;
        en_update_hash = 1'b0;
        s_update_hash  = 1'b0;
        en_fill_chunks = 1'b0;
        en_read_1      = 1'b0;
        en_read_2      = 1'b0;
        en_read_3      = 1'b0;
        en_read_4      = 1'b0;
        en_fill_1      = 1'b0;
        en_fill_2      = 1'b0;
        en_fill_3      = 1'b0;
        en_fill_4      = 1'b0;
        s_fk           = FK_NONE;
        case (state_q)
            S_INIT: begin
                en_j           = 1'b1;
                s_j            = 1'b1;
                en_l           = 1'b1;
                s_l            = 1'b1;
                en_reassign    = 1'b1;
                s_reassign     = 1'b1;
                en_update_hash = 1'b1;
                s_update_hash  = 1'b1;
                en_done        = 1'b1;
                s_done         = 1'b1;
            end
            S_RD1: en_read_1 = 1'b1;
            S_F1: begin
                en_fill_1 = 1'b1;
                en_read_2 = 1'b1;
            end
            S_F2: begin
                en_fill_2 = 1'b1;
                en_read_3 = 1'b1;
            end
            S_F3: begin
                en_fill_3 = 1'b1;
                en_read_4 = 1'b1;
            end
            S_F4:  en_fill_4      = 1'b1;
            S_WR:  en_fill_chunks = 1'b1;
            S_INC: en_j           = 1'b1;
            S_RNDINIT: begin
                en_l      = 1'b1;
                s_l       = 1'b1;
                en_read_1 = 1'b1;
            end
            S_RL: begin
                en_read_l = 1'b1;
                en_fk     = 1'b1;
                if (l_lt_choose) begin
                    s_fk = FK_CHOOSE;
                end else if (l_lt_parity_one) begin
                    s_fk = FK_PAR1;
                end else if (l_lt_major) begin
                    s_fk = FK_MAJOR;
                end else begin
                    s_fk = FK_PAR2;
                end
            end
            S_RT: en_temp = 1'b1;
            S_RA: begin
                en_reassign = 1'b1;
                en_l        = 1'b1;
            end
            S_HASH: en_update_hash = 1'b1;
            S_DONE: en_done        = 1'b1;
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sha1_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha1_controller
//  Description : Bench for sha1_controller. A behavioural SHA-1 datapath is
//                driven by the controller; digests are compared against an
//                independent SHA-1 reference through an expected-value queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sha1_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic j_lt_chunks, l_lt_choose, l_lt_parity_one, l_lt_major, l_lt_parity_two;
    logic busy, en_j, s_j, en_l, s_l, en_read_l, en_reassign, s_reassign;
    logic en_temp, s_temp, en_done, s_done, en_fk, en_update_hash, s_update_hash;
    logic en_fill_chunks, en_read_1, en_read_2, en_read_3, en_read_4;
    logic en_fill_1, en_fill_2, en_fill_3, en_fill_4;
    logic [2:0] s_fk;

    sha1_controller dut (
        .clk(clk), .rst(rst), .start(start),
        .j_lt_chunks(j_lt_chunks), .l_lt_choose(l_lt_choose),
        .l_lt_parity_one(l_lt_parity_one), .l_lt_major(l_lt_major),
        .l_lt_parity_two(l_lt_parity_two),
        .busy(busy), .en_j(en_j), .s_j(s_j), .en_l(en_l), .s_l(s_l),
        .en_read_l(en_read_l), .en_reassign(en_reassign), .s_reassign(s_reassign),
        .en_temp(en_temp), .s_temp(s_temp), .en_done(en_done), .s_done(s_done),
        .en_fk(en_fk), .en_update_hash(en_update_hash), .s_update_hash(s_update_hash),
        .en_fill_chunks(en_fill_chunks), .en_read_1(en_read_1), .en_read_2(en_read_2),
        .en_read_3(en_read_3), .en_read_4(en_read_4), .en_fill_1(en_fill_1),
        .en_fill_2(en_fill_2), .en_fill_3(en_fill_3), .en_fill_4(en_fill_4),
        .s_fk(s_fk)
    );

    always #5 clk = ~clk;

    localparam logic [159:0] IV = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE,
                                   32'h10325476, 32'hC3D2E1F0};

    int checks = 0;
    int errors = 0;

    wire [25:0] all_out = {busy, en_j, s_j, en_l, s_l, en_read_l, en_reassign,
                           s_reassign, en_temp, s_temp, en_done, s_done, en_fk,
                           en_update_hash, s_update_hash, en_fill_chunks,
                           en_read_1, en_read_2, en_read_3, en_read_4, en_fill_1,
                           en_fill_2, en_fill_3, en_fill_4, s_fk};

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Straightforward SHA-1 compression of one 512-bit block.
    function automatic logic [159:0] sha1_ref(input logic [511:0] m);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
        for (int i = 16; i < 80; i++) w[i] = rotl(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
        {a, b, c, d, e} = IV;
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            t = rotl(a, 5) + f + e + k + w[i];
            e = d; d = c; c = rotl(b, 30); b = a; a = t;
        end
        return {IV[159:128] + a, IV[127:96] + b, IV[95:64] + c, IV[63:32] + d, IV[31:0] + e};
    endfunction

    // ---------------- behavioural datapath driven by the controller -------
    logic [31:0] msg_mem [16];
    logic [31:0] wexp [80];
    logic [6:0]  j = 7'd0;
    logic [6:0]  l = 7'd0;
    logic [31:0] ram_q, fl1, fl2, fl3, fl4, f_q, k_q, t_q;
    logic [31:0] ra, rb, rc, rd_, re;
    logic [31:0] h0, h1, h2, h3, h4;
    logic        done = 1'b0;

    assign j_lt_chunks     = (j < 7'd80);
    assign l_lt_choose     = (l < 7'd20);
    assign l_lt_parity_one = (l < 7'd40);
    assign l_lt_major      = (l < 7'd60);
    assign l_lt_parity_two = (l < 7'd80);

    function automatic logic [31:0] rdw(input int idx);
        if (idx < 0 || idx > 79) return 32'h0;
        if (idx < 16) return msg_mem[idx];
        return wexp[idx];
    endfunction

    always @(posedge clk) begin
        if (en_j) j <= s_j ? 7'd16 : j + 7'd1;
        if (en_l) l <= s_l ? 7'd0 : l + 7'd1;
        if (en_read_1)      ram_q <= rdw(int'(j) - 3);
        else if (en_read_2) ram_q <= rdw(int'(j) - 8);
        else if (en_read_3) ram_q <= rdw(int'(j) - 14);
        else if (en_read_4) ram_q <= rdw(int'(j) - 16);
        else if (en_read_l) ram_q <= rdw(int'(l));
        if (en_fill_1) fl1 <= ram_q;
        if (en_fill_2) fl2 <= ram_q;
        if (en_fill_3) fl3 <= ram_q;
        if (en_fill_4) fl4 <= ram_q;
        if (en_fill_chunks && j < 7'd80) wexp[int'(j)] <= rotl(fl1 ^ fl2 ^ fl3 ^ fl4, 1);
        if (en_fk) begin
            case (s_fk)
                3'd1:    begin f_q <= (rb & rc) | (~rb & rd_);            k_q <= 32'h5A827999; end
                3'd2:    begin f_q <= rb ^ rc ^ rd_;                      k_q <= 32'h6ED9EBA1; end
                3'd4:    begin f_q <= (rb & rc) | (rb & rd_) | (rc & rd_); k_q <= 32'h8F1BBCDC; end
                3'd3:    begin f_q <= rb ^ rc ^ rd_;                      k_q <= 32'hCA62C1D6; end
                default: begin f_q <= 32'h0;                              k_q <= 32'h0;        end
            endcase
        end
        if (en_temp) t_q <= rotl(ra, 5) + f_q + re + k_q + ram_q;
        if (en_reassign) begin
            if (s_reassign) {ra, rb, rc, rd_, re} <= IV;
            else begin
                ra <= t_q; rb <= ra; rc <= rotl(rb, 30); rd_ <= rc; re <= rd_;
            end
        end
        if (en_update_hash) begin
            if (s_update_hash) {h0, h1, h2, h3, h4} <= IV;
            else begin
                h0 <= h0 + ra; h1 <= h1 + rb; h2 <= h2 + rc; h3 <= h3 + rd_; h4 <= h4 + re;
            end
        end
        if (en_done) done <= !s_done;
    end

    // ---------------- scoreboard monitor ---------------------------------
    logic [159:0] exp_q [$];
    int  n_done = 0;
    int  cyc_n = 0;
    int  t_start = 0;
    bit  in_run = 0;
    bit  busy_p = 0;
    bit  done_p = 0;
    int  n_fill, n_temp, rnd, bad_sp, conf, busy_low;
    int  r1, r2, r3;

    always @(negedge clk) begin
        logic [2:0]   fk_exp;
        logic [159:0] e_dig;
        cyc_n++;
        if (busy && !busy_p) begin
            t_start = cyc_n; in_run = 1;
            n_fill = 0; n_temp = 0; rnd = 0; bad_sp = 0; conf = 0; busy_low = 0;
            r1 = 0; r2 = 0; r3 = 0;
        end
        if ((s_j && !en_j) || (s_l && !en_l) || (s_reassign && !en_reassign) ||
            (s_temp && !en_temp) || (s_done && !en_done) ||
            (s_update_hash && !en_update_hash) || (s_fk != 3'd0 && !en_fk) || s_temp)
            conf++;
        if (in_run) begin
            if (!busy && !done) busy_low++;
            if (en_fill_chunks) n_fill++;
            if (en_temp) n_temp++;
            if (en_read_1 && !en_l) r1 = cyc_n;
            if (en_read_2) begin if (cyc_n - r1 != 2) bad_sp++; r2 = cyc_n; end
            if (en_read_3) begin if (cyc_n - r2 != 2) bad_sp++; r3 = cyc_n; end
            if (en_read_4) begin if (cyc_n - r3 != 2) bad_sp++; end
            if (en_read_l) begin
                fk_exp = (rnd < 20) ? 3'd1 : (rnd < 40) ? 3'd2 : (rnd < 60) ? 3'd4 : 3'd3;
                checks++;
                if (s_fk !== fk_exp) begin
                    errors++;
                    $display("FAIL s_fk round %0d: got %0d want %0d", rnd, s_fk, fk_exp);
                end
                rnd++;
            end
        end
        if (done && !done_p && in_run) begin
            in_run = 0;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL digest: got %h but no expected entry queued", {h0, h1, h2, h3, h4});
            end else begin
                e_dig = exp_q.pop_front();
                if ({h0, h1, h2, h3, h4} !== e_dig) begin
                    errors++;
                    $display("FAIL digest: got %h want %h", {h0, h1, h2, h3, h4}, e_dig);
                end
            end
            checks++;
            if (cyc_n - t_start != 1172) begin
                errors++;
                $display("FAIL latency: got %0d edges want 1172", cyc_n - t_start);
            end
            checks++;
            if (n_fill != 64 || n_temp != 80) begin
                errors++;
                $display("FAIL pulse_counts: fill %0d temp %0d want 64 80", n_fill, n_temp);
            end
            checks++;
            if (bad_sp != 0 || conf != 0 || busy_low != 0) begin
                errors++;
                $display("FAIL run_integrity: spacing %0d conflicts %0d busy_low %0d want 0 0 0",
                         bad_sp, conf, busy_low);
            end
            n_done++;
        end
        busy_p = busy;
        done_p = done;
    end

    // ---------------- stimulus -------------------------------------------
    task automatic load_msg(input logic [511:0] m);
        for (int i = 0; i < 16; i++) msg_mem[i] = m[511 - 32*i -: 32];
    endtask

    task automatic rand_msg(output logic [511:0] m);
        for (int i = 0; i < 16; i++) m[511 - 32*i -: 32] = $urandom();
    endtask

    task automatic wait_done(input int prev);
        int t = 0;
        while (n_done == prev && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        if (n_done == prev) begin
            checks++; errors++;
            $display("FAIL timeout: done count %0d want %0d", n_done, prev + 1);
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_msg(input logic [511:0] m, input logic [159:0] e);
        int prev;
        prev = n_done;
        load_msg(m);
        exp_q.push_back(e);
        pulse_start();
        wait_done(prev);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        logic [511:0] m, m2;
        int prev, k, t;

        // Outputs must be zero under reset before any clock edge.
        #1;
        chk("reset_outputs", 32'(all_out), 32'h0);
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs_clocked", 32'(all_out), 32'h0);
        rst = 1'b0;
        @(negedge clk); #1;

        // Padded "abc" against its published digest.
        m = {32'h61626380, {14{32'h0}}, 32'h00000018};
        run_msg(m, 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D);

        // Random blocks.
        for (int i = 0; i < 3; i++) begin
            rand_msg(m);
            run_msg(m, sha1_ref(m));
        end

        // Reset asserted in RT of round 37, then a fresh run.
        rand_msg(m);
        load_msg(m);
        exp_q.push_back(sha1_ref(m));
        pulse_start();
        k = 0; t = 0;
        while (t < 3000) begin
            @(negedge clk); #1;
            t++;
            if (en_temp) begin
                if (k == 37) break;
                k++;
            end
        end
        chk("reached_round37_rt", 32'(k), 32'd37);
        rst = 1'b1;
        #1;
        chk("midrun_reset_outputs", 32'(all_out), 32'h0);
        void'(exp_q.pop_back());
        @(negedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        rand_msg(m);
        run_msg(m, sha1_ref(m));

        // Back-to-back messages; second INIT must clear done.
        rand_msg(m);
        rand_msg(m2);
        run_msg(m, sha1_ref(m));
        prev = n_done;
        load_msg(m2);
        exp_q.push_back(sha1_ref(m2));
        pulse_start();
        chk("done_held_in_init", 32'(done), 32'd1);
        @(negedge clk); #1;
        chk("done_cleared_by_init", 32'(done), 32'd0);
        wait_done(prev);

        // start held high: one run, one IDLE cycle, immediate restart.
        rand_msg(m);
        load_msg(m);
        exp_q.push_back(sha1_ref(m));
        exp_q.push_back(sha1_ref(m));
        prev = n_done;
        start = 1'b1;
        wait_done(prev);
        chk("idle_at_done", 32'(busy), 32'd0);
        @(negedge clk); #1;
        chk("idle_exit_next_edge", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(prev + 1);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
